// File: rtl/wait_xfer_sequencer_pkg.sv
// Shared state encoding for the wait/transfer sequencer.
// Encoding is fixed so that state values seen in waveforms and debug taps stay stable.
package wait_xfer_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_EN = 2'd1,
        ST_DLY1    = 2'd2,
        ST_DLY2    = 2'd3
    } state_t;

endpackage

// File: rtl/wait_xfer_sequencer_delay_cnt.sv
// seq_delay_cnt: loadable down-counter that saturates at zero and flags zero.
// Latency: load and decrement take effect at the next edge; zero is combinational from the count.
// Backpressure: none; it decrements only when dec is high.
module seq_delay_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/wait_xfer_sequencer.sv
// Sequencer for "wait (!enable) #D1 a = b; #D2 c = d;" driven by a start pulse.
// Latency: a_out updates DELAY1 edges after enable is sampled low, c_out DELAY2 edges later.
// Backpressure: start is accepted only in IDLE; WAIT_TIMEOUT_EN adds a bounded enable wait.
module wait_xfer_sequencer
    import wait_xfer_sequencer_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int CNT_W   = 8,
    parameter int DELAY1  = 10,
    parameter int DELAY2  = 10,
    parameter int TIMEOUT = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             enable,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] c_out,
    output logic             a_wr,
    output logic             c_wr,
    output logic             busy,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] L_D1_M1 = CNT_W'(DELAY1 - 1);
    localparam logic [CNT_W-1:0] L_D2_M1 = CNT_W'(DELAY2 - 1);

    if ((DELAY1 < 1) || (DELAY1 > (2 ** CNT_W) - 1) ||
        (DELAY2 < 1) || (DELAY2 > (2 ** CNT_W) - 1) || (TIMEOUT < 1)) begin : g_bad_param
        $error("wait_xfer_sequencer: DELAY1/DELAY2/TIMEOUT out of range");
    end

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_cnt_zero;
    logic             w_xfer_a;
    logic             w_xfer_c;
    logic             w_tmo;
    logic             w_wait_expired;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_c;
    logic             r_a_wr;
    logic             r_c_wr;

    seq_delay_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        w_xfer_a   = 1'b0;
        w_xfer_c   = 1'b0;
        w_tmo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_WAIT_EN;
            end
            ST_WAIT_EN: begin
                // enable low on the expiry edge still wins over the timeout
                if (!enable) begin
                    w_next     = ST_DLY1;
                    w_load     = 1'b1;
                    w_load_val = L_D1_M1;
                end else if (w_wait_expired) begin
                    w_next = ST_IDLE;
                    w_tmo  = 1'b1;
                end
            end
            ST_DLY1: begin
                if (w_cnt_zero) begin
                    w_next     = ST_DLY2;
                    w_xfer_a   = 1'b1;
                    w_load     = 1'b1;
                    w_load_val = L_D2_M1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_DLY2: begin
                if (w_cnt_zero) begin
                    w_next   = ST_IDLE;
                    w_xfer_c = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_c     <= '0;
            r_a_wr  <= 1'b0;
            r_c_wr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_a_wr  <= w_xfer_a;
            r_c_wr  <= w_xfer_c;
            if (w_xfer_a) r_a <= b_in;
            if (w_xfer_c) r_c <= d_in;
        end
    end

`ifdef WAIT_TIMEOUT_EN
    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WCNT_W-1:0] r_wcnt;
    logic              r_timeout;

    // Outside WAIT_EN the counter sits at zero, so every wait starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo;
            if (r_state != ST_WAIT_EN) begin
                r_wcnt <= '0;
            end else if (enable && !w_wait_expired) begin
                r_wcnt <= r_wcnt + WCNT_W'(1);
            end
        end
    end

    assign w_wait_expired = (r_wcnt == WCNT_W'(TIMEOUT - 1));
    assign timeout        = r_timeout;
`else
    assign w_wait_expired = 1'b0;
    assign timeout        = 1'b0;
`endif

    assign a_out = r_a;
    assign c_out = r_c;
    assign a_wr  = r_a_wr;
    assign c_wr  = r_c_wr;
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wait_xfer_sequencer.sv
// Bench for wait_xfer_sequencer: two instances (10/10 and 1/1 delays) share one stimulus stream.
// The reference tracks each sequence by edge timestamps; WAIT_TIMEOUT_EN enables the timeout rule.
module tb_wait_xfer_sequencer;

    localparam int W    = 8;
    localparam int TMO  = 4;
    localparam int D1_A = 10;
    localparam int D2_A = 10;
    localparam int D1_B = 1;
    localparam int D2_B = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         enable = 1'b1;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] d_in = '0;

    logic [W-1:0] a_out   [2];
    logic [W-1:0] c_out   [2];
    logic         a_wr    [2];
    logic         c_wr    [2];
    logic         busy    [2];
    logic         timeout [2];

    int n_tests = 0;
    int n_fail  = 0;
    int n_edge  = 0;

    // Reference: per instance, edge of acceptance and edge of enable-low sample.
    bit           m_active [2];
    int           m_es     [2];
    int           m_e0     [2];
    logic [W-1:0] m_a      [2];
    logic [W-1:0] m_c      [2];
    bit           m_awr    [2];
    bit           m_cwr    [2];
    bit           m_tmo    [2];

    always #5 clk = ~clk;

    wait_xfer_sequencer #(.WIDTH(W), .CNT_W(8), .DELAY1(D1_A), .DELAY2(D2_A), .TIMEOUT(TMO)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .enable(enable), .b_in(b_in), .d_in(d_in),
        .a_out(a_out[0]), .c_out(c_out[0]), .a_wr(a_wr[0]), .c_wr(c_wr[0]),
        .busy(busy[0]), .timeout(timeout[0])
    );

    wait_xfer_sequencer #(.WIDTH(W), .CNT_W(8), .DELAY1(D1_B), .DELAY2(D2_B), .TIMEOUT(TMO)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .enable(enable), .b_in(b_in), .d_in(d_in),
        .a_out(a_out[1]), .c_out(c_out[1]), .a_wr(a_wr[1]), .c_wr(c_wr[1]),
        .busy(busy[1]), .timeout(timeout[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, n_edge, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_es[i]     = 0;
            m_e0[i]     = -1;
            m_a[i]      = '0;
            m_c[i]      = '0;
            m_awr[i]    = 1'b0;
            m_cwr[i]    = 1'b0;
            m_tmo[i]    = 1'b0;
        end
    endtask

    task automatic model_step(input int n, input logic st, input logic en,
                              input logic [W-1:0] b, input logic [W-1:0] d);
        for (int i = 0; i < 2; i++) begin
            int  d1;
            int  d2;
            bit  was_active;
            d1 = (i == 0) ? D1_A : D1_B;
            d2 = (i == 0) ? D2_A : D2_B;
            was_active = m_active[i];
            m_awr[i] = 1'b0;
            m_cwr[i] = 1'b0;
            m_tmo[i] = 1'b0;
            if (was_active) begin
                if (m_e0[i] < 0) begin
                    if (!en) begin
                        m_e0[i] = n;
                    end
`ifdef WAIT_TIMEOUT_EN
                    else if (n - m_es[i] == TMO) begin
                        m_tmo[i]    = 1'b1;
                        m_active[i] = 1'b0;
                    end
`endif
                end
                if (m_e0[i] >= 0 && n == m_e0[i] + d1) begin
                    m_a[i]   = b;
                    m_awr[i] = 1'b1;
                end
                if (m_e0[i] >= 0 && n == m_e0[i] + d1 + d2) begin
                    m_c[i]      = d;
                    m_cwr[i]    = 1'b1;
                    m_active[i] = 1'b0;
                end
            end else if (st) begin
                m_active[i] = 1'b1;
                m_es[i]     = n;
                m_e0[i]     = -1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("a_out%0d", i),   32'(a_out[i]),   32'(m_a[i]));
            chk($sformatf("c_out%0d", i),   32'(c_out[i]),   32'(m_c[i]));
            chk($sformatf("a_wr%0d", i),    32'(a_wr[i]),    32'(m_awr[i]));
            chk($sformatf("c_wr%0d", i),    32'(c_wr[i]),    32'(m_cwr[i]));
            chk($sformatf("busy%0d", i),    32'(busy[i]),    32'(m_active[i]));
            chk($sformatf("timeout%0d", i), 32'(timeout[i]), 32'(m_tmo[i]));
        end
    endtask

    // Drive at the falling edge, let the DUT sample at the rising edge, compare at the next falling edge.
    task automatic cycle(input logic st, input logic en, input logic [W-1:0] b, input logic [W-1:0] d);
        start  = st;
        enable = en;
        b_in   = b;
        d_in   = d;
        @(posedge clk);
        n_edge++;
        model_step(n_edge, st, en, b, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int en_run;
        logic en_lvl;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Enable already low: transfers follow acceptance directly.
        for (int k = 0; k < 35; k++) cycle(k == 4, 1'b0, 8'h5A, 8'hC3);

        // Enable held high, then low; enable bounces and stray starts while busy.
        for (int k = 0; k < 70; k++)
            cycle((k == 2) || (k == 20) || (k == 45), (k < 3) || (k >= 36 && k < 50),
                  W'(k), W'(k * 3));

        // Abort mid-sequence and confirm nothing fires afterwards without a new start.
        for (int k = 0; k < 6; k++) cycle(k == 0, 1'b0, 8'hAA, 8'h55);
        async_reset();
        for (int k = 0; k < 30; k++) cycle(1'b0, 1'b0, 8'hFF, 8'hFF);

        // Randomised traffic with run-length enable and occasional resets.
        en_run = 0;
        en_lvl = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (en_run == 0) begin
                en_lvl = ($urandom_range(0, 1) == 1);
                en_run = $urandom_range(1, 12);
            end
            en_run--;
            cycle($urandom_range(0, 5) == 0, en_lvl, W'($urandom), W'($urandom));
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
